// File: rtl/ovl_bus_arb_pkg.sv
// rtl/ovl_bus_arb_pkg.sv - shared state encoding and round-robin helper for the bus driver arbiter
package ovl_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        QUIET = 2'd2
    } arb_state_t;

    // First requester above 'last', wrapping modulo n (n <= 32). Returns 'last' when nobody requests.
    function automatic int rr_pick(input logic [31:0] req, input int last, input int n);
        int   idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k <= n && !found) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// rtl/ovl_rr_pick.sv - combinational round-robin priority selector
module ovl_rr_pick
    import ovl_bus_arb_pkg::*;
#(
    parameter int num_drivers = 2
) (
    input  logic [num_drivers-1:0]         req,
    input  logic [$clog2(num_drivers)-1:0] last,
    output logic [$clog2(num_drivers)-1:0] winner,
    output logic                           any
);

    localparam int id_w = $clog2(num_drivers);

    assign any    = |req;
    assign winner = id_w'(rr_pick(32'(req), int'(last), num_drivers));

endmodule

// File: rtl/ovl_bus_driver_arbiter.sv
// rtl/ovl_bus_driver_arbiter.sv - round-robin bus driver with enforced quiet gap between owners
module ovl_bus_driver_arbiter
    import ovl_bus_arb_pkg::*;
#(
    parameter int num_drivers = 2,
    parameter int width       = 2,
    parameter int min_quiet   = 1,
    parameter int max_hold    = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [num_drivers-1:0]         req,
    input  logic [num_drivers*width-1:0]   drv_data,
    input  logic                           force_overlap,
    output logic [num_drivers-1:0]         driver_enables,
    output logic [width-1:0]               test_expr,
    output logic [$clog2(num_drivers)-1:0] grant_id,
    output logic [7:0]                     handover_cnt
);

    localparam int id_w    = $clog2(num_drivers);
    localparam int hold_w  = $clog2(max_hold + 1);
    localparam int quiet_w = $clog2(min_quiet + 1);
    localparam logic [hold_w-1:0]  hold_max  = hold_w'(max_hold);
    localparam logic [quiet_w-1:0] quiet_max = quiet_w'(min_quiet);
    localparam logic [id_w-1:0]    last_id   = id_w'(num_drivers - 1);

    arb_state_t          state, state_n;
    logic [hold_w-1:0]   hold, hold_n;
    logic [quiet_w-1:0]  quiet, quiet_n;
    logic [num_drivers-1:0] en_n;
    logic [width-1:0]    tx_n;
    logic [id_w-1:0]     gid_n;
    logic [7:0]          ho_n;
    logic [id_w-1:0]     winner;
    logic [id_w-1:0]     next_id;
    logic                any_req;
    logic                do_grant;
    logic [width-1:0]    data_arr [num_drivers];

    for (genvar i = 0; i < num_drivers; i++) begin : g_slice
        assign data_arr[i] = drv_data[i*width +: width];
    end

    ovl_rr_pick #(.num_drivers(num_drivers)) u_pick (
        .req    (req),
        .last   (grant_id),
        .winner (winner),
        .any    (any_req)
    );

    assign next_id = (grant_id == last_id) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            driver_enables <= '0;
            test_expr      <= '0;
            grant_id       <= last_id;
            hold           <= '0;
            quiet          <= '0;
            handover_cnt   <= '0;
        end else if (enable) begin
            state          <= state_n;
            driver_enables <= en_n;
            test_expr      <= tx_n;
            grant_id       <= gid_n;
            hold           <= hold_n;
            quiet          <= quiet_n;
            handover_cnt   <= ho_n;
        end
    end

    always_comb begin
        state_n  = state;
        en_n     = driver_enables;
        tx_n     = test_expr;
        gid_n    = grant_id;
        hold_n   = hold;
        quiet_n  = quiet;
        ho_n     = handover_cnt;
        do_grant = 1'b0;
        case (state)
            IDLE: begin
                en_n     = '0;
                tx_n     = '0;
                do_grant = any_req;
            end
            DRIVE: begin
                // Dropped request and hold expiry in the same cycle collapse into one release.
                if (!req[grant_id] || hold == hold_max) begin
                    en_n    = '0;
                    tx_n    = '0;
                    quiet_n = quiet_w'(1);
                    state_n = QUIET;
                    if (handover_cnt != 8'hff) ho_n = handover_cnt + 8'd1;
                end else begin
                    hold_n         = hold + 1'b1;
                    tx_n           = data_arr[grant_id];
                    en_n           = '0;
                    en_n[grant_id] = 1'b1;
                    if (force_overlap) en_n[next_id] = 1'b1;
                end
            end
            QUIET: begin
                en_n = '0;
                tx_n = '0;
                if (quiet == quiet_max) begin
                    if (any_req) do_grant = 1'b1;
                    else         state_n  = IDLE;
                end else begin
                    quiet_n = quiet + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = '0;
                tx_n    = '0;
            end
        endcase
        if (do_grant) begin
            state_n      = DRIVE;
            en_n         = '0;
            en_n[winner] = 1'b1;
            tx_n         = data_arr[winner];
            gid_n        = winner;
            hold_n       = hold_w'(1);
        end
    end

endmodule
